m_mem_controller: RTL and testbench

- Sequences the memory stage of the 5-stage Y86-64 pipeline.
- Decodes the instruction held in the M pipeline register and issues a single read or write to a variable-latency data memory over a req/ack handshake.
- Stalls F/D/E/M and bubbles W until the access completes, then presents m_valM and m_stat to the W register.
- Detects address errors and memory timeouts, and keeps a stall-cycle performance counter.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/mem_timeout_ctr.sv | 29 ++
 rtl/m_mem_controller.sv | 142 ++++++++++++++
 tb/tb_m_mem_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage:
// instruction codes, status codes and controller states.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Busy-cycle counter for the memory stage; cleared when an
// access starts, flags expiry on the last permitted cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/m_mem_controller.sv
// Memory-stage sequencer: one req/ack access per M instruction,
// stalling the pipe until the variable-latency memory answers.
module m_mem_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_SIZE = 64'h1_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       M_stat,
    input  logic [3:0]       M_icode,
    input  logic [63:0]      M_valE,
    input  logic [63:0]      M_valA,
    output logic             mem_req,
    output logic             mem_we,
    output logic [63:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_err,
    output logic [63:0]      m_valM,
    output logic [2:0]       m_stat,
    output logic             mem_stall,
    output logic             W_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    mem_state_e  state, state_nx;
    logic        is_rd, is_wr;
    logic [63:0] addr;
    logic        mem_op, addr_err;
    logic        start, expire, finish;
    logic [63:0] res_valM;
    logic [2:0]  res_stat;

    always_comb begin
        is_rd = 1'b0;
        is_wr = 1'b0;
        addr  = M_valE;
        unique case (M_icode)
            IMRMOVQ: is_rd = 1'b1;
            IPOPQ, IRET: begin
                is_rd = 1'b1;
                addr  = M_valA;
            end
            IRMMOVQ, IPUSHQ, ICALL: is_wr = 1'b1;
            default: ;
        endcase
    end

    assign mem_op   = (M_stat == SAOK) && (is_rd || is_wr);
    assign addr_err = mem_op && (addr > (MEM_SIZE - 64'd8));

    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        m_stat    = M_stat;
        m_valM    = '0;
        start     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (addr_err) begin
                    m_stat = SADR;
                end else if (mem_op) begin
                    mem_stall = 1'b1;
                    start     = 1'b1;
                    state_nx  = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_stall = 1'b1;
                if (mem_ack || expire) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                m_stat   = res_stat;
                m_valM   = res_valM;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign finish   = (state == S_BUSY) && (mem_ack || expire);
    assign W_bubble = mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            res_valM  <= '0;
            res_stat  <= SAOK;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= is_wr;
            mem_addr  <= addr;
            mem_wdata <= M_valA;
        end else if (finish) begin
            mem_req <= 1'b0;
            // a late ack still beats the timeout on the same cycle
            if (mem_ack) begin
                res_valM <= mem_we ? 64'd0 : mem_rdata;
                res_stat <= mem_err ? SADR : SAOK;
            end else begin
                res_valM <= '0;
                res_stat <= SADR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (mem_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (state == S_BUSY),
        .expire(expire)
    );

endmodule

// File: tb/tb_m_mem_controller.sv
// Scoreboard bench for the memory-stage controller with a
// per-access programmable-latency memory responder.
module tb_m_mem_controller;
    import y86_pkg::*;

    localparam int          CNT_W   = 5;
    localparam int          CMAX    = (1 << CNT_W) - 1;
    localparam logic [63:0] MSIZE   = 64'h1_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       M_stat;
    logic [3:0]       M_icode;
    logic [63:0]      M_valE, M_valA;
    logic             mem_req, mem_we;
    logic [63:0]      mem_addr, mem_wdata;
    logic             mem_ack;
    logic [63:0]      mem_rdata;
    logic             mem_err;
    logic [63:0]      m_valM;
    logic [2:0]       m_stat;
    logic             mem_stall, W_bubble;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] valM;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt_model = 0;

    always #5 clk = ~clk;

    m_mem_controller #(
        .MEM_SIZE(MSIZE),
        .TIMEOUT (16),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .M_stat   (M_stat),
        .M_icode  (M_icode),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mem_err  (mem_err),
        .m_valM   (m_valM),
        .m_stat   (m_stat),
        .mem_stall(mem_stall),
        .W_bubble (W_bubble),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        M_stat  = SAOK;
        M_icode = INOP;
        M_valE  = '0;
        M_valA  = '0;
        mem_ack = 1'b0;
        mem_err = 1'b0;
    endtask

    task automatic run_op(
        input string       tag,
        input logic [3:0]  ic,
        input logic [2:0]  st,
        input logic [63:0] ve,
        input logic [63:0] va,
        input int          lat,
        input logic [63:0] rd,
        input logic        er,
        input logic [2:0]  x_stat,
        input logic [63:0] x_valM,
        input int          x_stall,
        input int          x_req,
        input logic        x_we,
        input logic [63:0] x_addr
    );
        exp_t e;
        int   stalls, reqs, n;
        bit   done;
        @(negedge clk);
        M_icode = ic;
        M_stat  = st;
        M_valE  = ve;
        M_valA  = va;
        mem_ack = 1'b0;
        sb.push_back('{stat: x_stat, valM: x_valM});
        stalls = 0;
        reqs   = 0;
        n      = 0;
        done   = 1'b0;
        while (!done && n < 64) begin
            #1;
            chk({tag, ".bubble"}, 64'(W_bubble), 64'(mem_stall));
            if (mem_req) begin
                if (reqs == 0) begin
                    chk({tag, ".we"}, 64'(mem_we), 64'(x_we));
                    chk({tag, ".addr"}, mem_addr, x_addr);
                    if (x_we) chk({tag, ".wdata"}, mem_wdata, va);
                end
                mem_ack   = (reqs == lat);
                mem_err   = (reqs == lat) ? er : 1'b0;
                mem_rdata = rd;
                reqs++;
            end else begin
                mem_ack = 1'b0;
                mem_err = 1'b0;
            end
            if (mem_stall) begin
                stalls++;
            end else begin
                e = sb.pop_front();
                chk({tag, ".stat"}, 64'(m_stat), 64'(e.stat));
                chk({tag, ".valM"}, m_valM, e.valM);
                done = 1'b1;
            end
            n++;
            if (!done) @(negedge clk);
        end
        chk({tag, ".finished"}, 64'(done), 64'd1);
        chk({tag, ".stalls"}, 64'(stalls), 64'(x_stall));
        chk({tag, ".reqs"}, 64'(reqs), 64'(x_req));
        @(posedge clk);
        #1;
        idle_inputs();
        cnt_model = cnt_model + x_stall;
        if (cnt_model > CMAX) cnt_model = CMAX;
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(cnt_model));
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_rdata = '0;
        idle_inputs();
        #1;
        chk("rst.req", 64'(mem_req), 64'd0);
        chk("rst.we", 64'(mem_we), 64'd0);
        chk("rst.addr", mem_addr, 64'd0);
        chk("rst.wdata", mem_wdata, 64'd0);
        chk("rst.cnt", 64'(stall_cnt), 64'd0);
        chk("rst.stall", 64'(mem_stall), 64'd0);
        chk("rst.stat", 64'(m_stat), 64'(SAOK));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mrmov", IMRMOVQ, SAOK, 64'h100, 64'h0, 2,
               64'hDEADBEEF, 1'b0, SAOK, 64'hDEADBEEF, 4, 3,
               1'b0, 64'h100);
        run_op("push", IPUSHQ, SAOK, 64'h1F8, 64'h55, 0,
               64'h1234, 1'b0, SAOK, 64'h0, 2, 1, 1'b1, 64'h1F8);
        run_op("adr_hi", IRMMOVQ, SAOK, MSIZE - 64'd7, 64'h9, 0,
               64'h0, 1'b0, SADR, 64'h0, 0, 0, 1'b0, 64'h0);
        run_op("adr_edge", IMRMOVQ, SAOK, MSIZE - 64'd8, 64'h0, 1,
               64'h77, 1'b0, SAOK, 64'h77, 3, 2, 1'b0, MSIZE - 64'd8);
        run_op("adr_wrap", IMRMOVQ, SAOK, 64'hFFFF_FFFF_FFFF_FFFC,
               64'h0, 0, 64'h0, 1'b0, SADR, 64'h0, 0, 0, 1'b0, 64'h0);
        run_op("pop_tmo", IPOPQ, SAOK, 64'h999, 64'h40, -1,
               64'h0, 1'b0, SADR, 64'h0, 17, 16, 1'b0, 64'h40);
        #1;
        chk("tmo.next_stall", 64'(mem_stall), 64'd0);
        chk("tmo.next_req", 64'(mem_req), 64'd0);
        run_op("rd_err", IMRMOVQ, SAOK, 64'h80, 64'h0, 1,
               64'hABC, 1'b1, SADR, 64'hABC, 3, 2, 1'b0, 64'h80);
        run_op("wr_err", IRMMOVQ, SAOK, 64'h88, 64'h66, 1,
               64'hABC, 1'b1, SADR, 64'h0, 3, 2, 1'b1, 64'h88);
        run_op("halt", IHALT, SHLT, 64'h0, 64'h0, 0,
               64'h0, 1'b0, SHLT, 64'h0, 0, 0, 1'b0, 64'h0);
        run_op("ins", IMRMOVQ, SINS, 64'h100, 64'h0, 0,
               64'h0, 1'b0, SINS, 64'h0, 0, 0, 1'b0, 64'h0);
        run_op("call", ICALL, SAOK, 64'h3F0, 64'h1122, 0,
               64'h0, 1'b0, SAOK, 64'h0, 2, 1, 1'b1, 64'h3F0);
        run_op("ret", IRET, SAOK, 64'h500, 64'h3F0, 0,
               64'h1122, 1'b0, SAOK, 64'h1122, 2, 1, 1'b0, 64'h3F0);

        @(negedge clk);
        M_icode = IMRMOVQ;
        M_valE  = 64'h200;
        @(negedge clk);
        #1;
        chk("rstbusy.req_before", 64'(mem_req), 64'd1);
        M_icode = INOP;
        rst_n   = 1'b0;
        #1;
        chk("rstbusy.req", 64'(mem_req), 64'd0);
        chk("rstbusy.stall", 64'(mem_stall), 64'd0);
        chk("rstbusy.cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 64'hBAD;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("late_ack.req", 64'(mem_req), 64'd0);
        chk("late_ack.cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        chk("late_ack.stall", 64'(mem_stall), 64'd0);
        chk("late_ack.stat", 64'(m_stat), 64'(SAOK));
        chk("late_ack.valM", m_valM, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
